// File: rtl/ldpc_decoder.sv
// Iterative min-sum decoder over a K x K grid of circulant blocks with row/column single-parity checks.
// Optional early termination on satisfied parities: define LDPC_EARLY_TERM_EN.
module ldpc_decoder #(
    parameter int L                    = 32,
    parameter int K                    = 6,
    parameter int ADDR_WIDTH           = 5,
    parameter int MESSAGE_WIDTH        = 5,
    parameter int CNU_DATA_IN_WIDTH    = 6,
    parameter int CNU_DATA_OUT_WIDTH   = 5,
    parameter int INTRINSIC_DATA_WIDTH = 5,
    parameter int ITERS                = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ext_reset,
    input  logic                     en,
    input  logic [K*K-1:0]           pe_select,
    input  logic [MESSAGE_WIDTH-1:0] int_in,
    input  logic [ADDR_WIDTH-1:0]    load_add_in,
    input  logic [ADDR_WIDTH-1:0]    read_add_in,
    input  logic [K-1:0]             column_select,
    output logic [K*K-1:0]           dec_out_fin,
    output logic [ADDR_WIDTH:0]      relay,
    output logic                     f_id
);
    localparam int NB     = K * K;
    localparam int MW     = MESSAGE_WIDTH;
    localparam int QW     = CNU_DATA_IN_WIDTH;
    localparam int IW     = INTRINSIC_DATA_WIDTH;
    localparam int SW     = IW + 2;
    localparam int ITW    = $clog2(ITERS + 1);
    localparam int MAGMAX = 2 ** (CNU_DATA_OUT_WIDTH - 1) - 1;
    localparam logic signed [QW:0] QMAX = (QW + 1)'(2 ** (QW - 1) - 1);
    localparam logic signed [QW:0] QMIN = (QW + 1)'(-(2 ** (QW - 1)));

    typedef enum logic [2:0] {S_LOAD, S_INIT, S_ROW, S_COL, S_WRITE} state_t;

    state_t                 state, state_next;
    logic [ADDR_WIDTH-1:0]  a, a_next;
    logic [ITW-1:0]         iter;
    logic signed [IW-1:0]   llr_mem [NB][L];
    logic                   hard_mem [NB][L];
    logic signed [MW-1:0]   r_reg [K][K];
    logic signed [MW-1:0]   c_reg [K][K];
    logic signed [MW-1:0]   r_new [K][K];
    logic signed [MW-1:0]   c_new [K][K];
    logic signed [IW-1:0]   llr_cur [NB];
    logic [K*QW-1:0]        q_row [K];
    logic [K*QW-1:0]        q_col [K];
    logic [NB-1:0]          hard_now;
    logic                   parity_ok;
    logic                   load_last;
    logic                   last_iter;

    function automatic logic signed [QW-1:0] sat_q(input logic signed [IW-1:0] llr,
                                                   input logic signed [MW-1:0] msg);
        logic signed [QW:0] s;
        s = (QW + 1)'(llr) + (QW + 1)'(msg);
        if (s > QMAX) begin
            sat_q = QMAX[QW-1:0];
        end else if (s < QMIN) begin
            sat_q = QMIN[QW-1:0];
        end else begin
            sat_q = s[QW-1:0];
        end
    endfunction

    // Sign product and minimum magnitude over all entries except the skipped one
    function automatic logic signed [MW-1:0] min_sum(input logic [K*QW-1:0] qs, input int skip);
        logic          sgn;
        logic [QW-1:0] q;
        logic [QW-1:0] mag;
        logic [QW-1:0] mn;
        sgn = 1'b0;
        mn  = {QW{1'b1}};
        for (int j = 0; j < K; j++) begin
            q   = qs[j*QW +: QW];
            mag = q[QW-1] ? (QW'(0) - q) : q;
            if (j != skip) begin
                sgn = sgn ^ q[QW-1];
                if (mag < mn) begin
                    mn = mag;
                end else begin
                    mn = mn;
                end
            end else begin
                sgn = sgn;
            end
        end
        if (mn > QW'(MAGMAX)) begin
            mn = QW'(MAGMAX);
        end else begin
            mn = mn;
        end
        min_sum = sgn ? -MW'(mn) : MW'(mn);
    endfunction

    function automatic logic hard_bit(input logic signed [IW-1:0] llr,
                                      input logic signed [MW-1:0] r,
                                      input logic signed [MW-1:0] c);
        logic signed [SW-1:0] s;
        s = SW'(llr) + SW'(r) + SW'(c);
        hard_bit = s[SW-1];
    endfunction

    assign load_last = pe_select[NB-1] && (load_add_in == ADDR_WIDTH'(L - 1));
    assign last_iter = (iter == ITW'(ITERS - 1));

    // Variable-to-check messages for the current address
    always_comb begin
        for (int x = 0; x < K; x++) begin
            q_row[x] = '0;
            q_col[x] = '0;
        end
        for (int b = 0; b < NB; b++) begin
            llr_cur[b] = llr_mem[b][a];
        end
        for (int x = 0; x < K; x++) begin
            for (int y = 0; y < K; y++) begin
                q_row[x][y*QW +: QW] = sat_q(llr_cur[x*K+y], c_reg[x][y]);
                q_col[y][x*QW +: QW] = sat_q(llr_cur[x*K+y], r_reg[x][y]);
            end
        end
    end

    // Check-node updates and the hard decision from the final messages
    always_comb begin
        for (int x = 0; x < K; x++) begin
            for (int y = 0; y < K; y++) begin
                r_new[x][y]      = min_sum(q_row[x], y);
                c_new[x][y]      = min_sum(q_col[y], x);
                hard_now[x*K+y]  = hard_bit(llr_cur[x*K+y], r_reg[x][y], c_reg[x][y]);
            end
        end
    end

`ifdef LDPC_EARLY_TERM_EN
    logic [NB-1:0] hard_term;
    logic [K-1:0]  row_par;
    logic [K-1:0]  col_par;

    // Parity of the tentative decision using the column messages being produced this cycle
    always_comb begin
        row_par = '0;
        col_par = '0;
        for (int x = 0; x < K; x++) begin
            for (int y = 0; y < K; y++) begin
                hard_term[x*K+y] = hard_bit(llr_cur[x*K+y], r_reg[x][y], c_new[x][y]);
                row_par[x]       = row_par[x] ^ hard_term[x*K+y];
                col_par[y]       = col_par[y] ^ hard_term[x*K+y];
            end
        end
        parity_ok = ~|{row_par, col_par};
    end
`else
    assign parity_ok = 1'b0;
`endif

    // Next-state and next-address logic; a frame restart overrides everything
    always_comb begin
        state_next = state;
        a_next     = a;
        if (ext_reset) begin
            state_next = S_LOAD;
            a_next     = '0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (load_last) begin
                        state_next = S_INIT;
                    end else begin
                        state_next = S_LOAD;
                    end
                end
                S_INIT:  state_next = S_ROW;
                S_ROW:   state_next = S_COL;
                S_COL: begin
                    if (last_iter || parity_ok) begin
                        state_next = S_WRITE;
                    end else begin
                        state_next = S_ROW;
                    end
                end
                S_WRITE: begin
                    if (a == ADDR_WIDTH'(L - 1)) begin
                        state_next = S_LOAD;
                        a_next     = '0;
                    end else begin
                        state_next = S_INIT;
                        a_next     = a + ADDR_WIDTH'(1);
                    end
                end
                default: begin
                    state_next = S_LOAD;
                    a_next     = '0;
                end
            endcase
        end
    end

    // State, address and status register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_LOAD;
            a     <= '0;
            relay <= '0;
        end else if (en) begin
            state <= state_next;
            a     <= a_next;
            relay <= {state_next != S_LOAD, a_next};
        end
    end

    // Iteration counter and check-to-variable message registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iter <= '0;
            for (int x = 0; x < K; x++) begin
                for (int y = 0; y < K; y++) begin
                    r_reg[x][y] <= '0;
                    c_reg[x][y] <= '0;
                end
            end
        end else if (en && !ext_reset) begin
            case (state)
                S_INIT: begin
                    iter <= '0;
                    for (int x = 0; x < K; x++) begin
                        for (int y = 0; y < K; y++) begin
                            r_reg[x][y] <= '0;
                            c_reg[x][y] <= '0;
                        end
                    end
                end
                S_ROW:   r_reg <= r_new;
                S_COL: begin
                    c_reg <= c_new;
                    iter  <= iter + ITW'(1);
                end
                default: iter <= iter;
            endcase
        end
    end

    // Intrinsic LLR memory, written only while loading
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < NB; b++) begin
                for (int i = 0; i < L; i++) begin
                    llr_mem[b][i] <= '0;
                end
            end
        end else if (en && !ext_reset && state == S_LOAD) begin
            for (int b = 0; b < NB; b++) begin
                if (pe_select[b]) begin
                    llr_mem[b][load_add_in] <= int_in;
                end
            end
        end
    end

    // Hard-decision memory, masked read port and frame-done toggle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_out_fin <= '0;
            f_id        <= 1'b0;
            for (int b = 0; b < NB; b++) begin
                for (int i = 0; i < L; i++) begin
                    hard_mem[b][i] <= 1'b0;
                end
            end
        end else if (en) begin
            for (int x = 0; x < K; x++) begin
                for (int y = 0; y < K; y++) begin
                    dec_out_fin[x*K+y] <= column_select[y] ? hard_mem[x*K+y][read_add_in] : 1'b0;
                end
            end
            if (!ext_reset && state == S_WRITE) begin
                for (int b = 0; b < NB; b++) begin
                    hard_mem[b][a] <= hard_now[b];
                end
                if (a == ADDR_WIDTH'(L - 1)) begin
                    f_id <= ~f_id;
                end
            end
        end
    end
endmodule

// File: tb/tb_ldpc_decoder.sv
// Self-checking bench for ldpc_decoder: directed frames, a read-port vector table and random
// frames compared against an integer min-sum reference model.
module tb_ldpc_decoder;
    localparam int NB = 36;
    localparam int NL = 32;
`ifdef LDPC_EARLY_TERM_EN
    localparam int EXP_CONST = 128;
    localparam int EXP_RAND  = -1;
`else
    localparam int EXP_CONST = 320;
    localparam int EXP_RAND  = 320;
`endif

    logic        clk = 1'b0;
    logic        reset, ext_reset, en;
    logic [35:0] pe_select;
    logic [4:0]  int_in, load_add_in, read_add_in;
    logic [5:0]  column_select;
    logic [35:0] dec_out_fin;
    logic [5:0]  relay;
    logic        f_id;

    int n_vec = 0;
    int n_err = 0;
    logic exp_fid;
    int llr_m [NB][NL];
    bit hard_m [NB][NL];

    typedef struct {
        logic [4:0]  addr;
        logic [5:0]  col;
        logic [35:0] exp;
    } rd_vec_t;
    rd_vec_t tbl [6];

    ldpc_decoder dut (
        .clk(clk), .reset(reset), .ext_reset(ext_reset), .en(en),
        .pe_select(pe_select), .int_in(int_in), .load_add_in(load_add_in),
        .read_add_in(read_add_in), .column_select(column_select),
        .dec_out_fin(dec_out_fin), .relay(relay), .f_id(f_id)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int sat6(input int v);
        return (v > 31) ? 31 : ((v < -32) ? -32 : v);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference min-sum decoding of every address from llr_m into hard_m
    task automatic ref_decode();
        int r [6][6];
        int c [6][6];
        int s, m, q, p;
        bit ok;
        for (int a = 0; a < NL; a++) begin
            for (int x = 0; x < 6; x++)
                for (int y = 0; y < 6; y++) begin r[x][y] = 0; c[x][y] = 0; end
            for (int it = 0; it < 4; it++) begin
                for (int x = 0; x < 6; x++)
                    for (int y = 0; y < 6; y++) begin
                        s = 0; m = 1000;
                        for (int j = 0; j < 6; j++) if (j != y) begin
                            q = sat6(llr_m[x*6+j][a] + c[x][j]);
                            if (q < 0) s ^= 1;
                            if (iabs(q) < m) m = iabs(q);
                        end
                        if (m > 15) m = 15;
                        r[x][y] = s ? -m : m;
                    end
                for (int x = 0; x < 6; x++)
                    for (int y = 0; y < 6; y++) begin
                        s = 0; m = 1000;
                        for (int i = 0; i < 6; i++) if (i != x) begin
                            q = sat6(llr_m[i*6+y][a] + r[i][y]);
                            if (q < 0) s ^= 1;
                            if (iabs(q) < m) m = iabs(q);
                        end
                        if (m > 15) m = 15;
                        c[x][y] = s ? -m : m;
                    end
`ifdef LDPC_EARLY_TERM_EN
                ok = 1'b1;
                for (int x = 0; x < 6; x++) begin
                    p = 0;
                    for (int y = 0; y < 6; y++) p ^= int'(llr_m[x*6+y][a] + r[x][y] + c[x][y] < 0);
                    if (p != 0) ok = 1'b0;
                end
                for (int y = 0; y < 6; y++) begin
                    p = 0;
                    for (int x = 0; x < 6; x++) p ^= int'(llr_m[x*6+y][a] + r[x][y] + c[x][y] < 0);
                    if (p != 0) ok = 1'b0;
                end
                if (ok) break;
`endif
            end
            for (int x = 0; x < 6; x++)
                for (int y = 0; y < 6; y++)
                    hard_m[x*6+y][a] = (llr_m[x*6+y][a] + r[x][y] + c[x][y]) < 0;
        end
    endtask

    task automatic load_const(input int v);
        int vv;
        vv = v;
        for (int a = 0; a < NL; a++) begin
            pe_select = '1; load_add_in = 5'(a); int_in = vv[4:0];
            step();
            for (int b = 0; b < NB; b++) llr_m[b][a] = v;
        end
        pe_select = '0;
        chk("relay_busy", 64'(relay), 64'(6'b100000));
        ref_decode();
    endtask

    task automatic load_frame();
        int v;
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < NL; a++) begin
                v = llr_m[b][a];
                pe_select = '0; pe_select[b] = 1'b1;
                load_add_in = 5'(a); int_in = v[4:0];
                step();
            end
        pe_select = '0;
        chk("relay_busy", 64'(relay), 64'(6'b100000));
        ref_decode();
    endtask

    task automatic rand_llrs(input bit noisy);
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < NL; a++)
                if (noisy) llr_m[b][a] = ($urandom_range(0, 99) < 15) ? -int'($urandom_range(1, 8))
                                                                      : int'($urandom_range(1, 15));
                else llr_m[b][a] = int'($urandom_range(0, 31)) - 16;
    endtask

    // Wait for the frame-done toggle, optionally holding en low for 20 cycles at pause_at
    task automatic run_decode(input int exp_cycles, input int pause_at, input string name);
        int cnt;
        logic f0;
        logic [5:0] rl;
        f0 = f_id; cnt = 0;
        while (f_id == f0 && cnt < 3000) begin
            if (cnt == pause_at) begin
                rl = relay; en = 1'b0;
                repeat (20) begin step(); cnt++; end
                chk({name, "_relay_frozen"}, 64'(relay), 64'(rl));
                en = 1'b1;
            end
            step(); cnt++;
        end
        exp_fid = ~exp_fid;
        chk({name, "_fid"}, 64'(f_id), 64'(exp_fid));
        if (exp_cycles >= 0) chk({name, "_cycles"}, 64'(cnt), 64'(exp_cycles));
        chk({name, "_idle"}, 64'(relay), 64'(0));
    endtask

    task automatic check_all(input string name);
        logic [35:0] e;
        for (int a = 0; a < NL; a++) begin
            read_add_in = 5'(a); column_select = '1;
            step();
            for (int b = 0; b < NB; b++) e[b] = hard_m[b][a];
            chk(name, 64'(dec_out_fin), 64'(e));
        end
    endtask

    initial begin
        reset = 1'b1; ext_reset = 1'b0; en = 1'b1; pe_select = '0; int_in = '0;
        load_add_in = '0; read_add_in = '0; column_select = '0; exp_fid = 1'b0;
        tbl[0] = '{5'd5,  6'b000001, 36'h041041041};
        tbl[1] = '{5'd0,  6'b111111, 36'hfffffffff};
        tbl[2] = '{5'd31, 6'b100000, 36'h820820820};
        tbl[3] = '{5'd17, 6'b000000, 36'h000000000};
        tbl[4] = '{5'd9,  6'b010101, 36'h555555555};
        tbl[5] = '{5'd22, 6'b101010, 36'haaaaaaaaa};

        repeat (3) step();
        chk("rst_dec", 64'(dec_out_fin), 64'(0));
        chk("rst_relay", 64'(relay), 64'(0));
        chk("rst_fid", 64'(f_id), 64'(0));
        reset = 1'b0;
        step();
        chk("post_rst_relay", 64'(relay), 64'(0));

        load_const(7);
        run_decode(EXP_CONST, -1, "pos7");
        check_all("pos7_hard");

        load_const(-8);
        run_decode(EXP_CONST, -1, "neg8");
        check_all("neg8_hard");
        for (int i = 0; i < 6; i++) begin
            read_add_in = tbl[i].addr; column_select = tbl[i].col;
            step();
            chk("read_table", 64'(dec_out_fin), 64'(tbl[i].exp));
        end
        read_add_in = 5'd0; column_select = 6'b000000;
        step();
        chk("lat_zero", 64'(dec_out_fin), 64'(0));
        read_add_in = 5'd5; column_select = 6'b000001;
        #2;
        chk("lat_hold", 64'(dec_out_fin), 64'(0));
        step();
        chk("lat_one", 64'(dec_out_fin), 64'(36'h041041041));

        for (int a = 0; a < NL - 1; a++) begin
            pe_select = '1; load_add_in = 5'(a); int_in = 5'd10;
            step();
        end
        pe_select = 36'd1; load_add_in = 5'd5; int_in = 5'b11101;
        step();
        pe_select = '1; load_add_in = 5'd31; int_in = 5'd10;
        step();
        pe_select = '0;
        for (int b = 0; b < NB; b++) for (int a = 0; a < NL; a++) llr_m[b][a] = 10;
        llr_m[0][5] = -3;
        ref_decode();
        run_decode(EXP_CONST, -1, "flip");
        read_add_in = 5'd5; column_select = 6'b000001;
        step();
        chk("flip_corrected", 64'(dec_out_fin), 64'(0));
        check_all("flip_hard");

        rand_llrs(1'b1); load_frame();
        run_decode(EXP_RAND, -1, "rnd_noisy");
        check_all("rnd_noisy_hard");
        rand_llrs(1'b0); load_frame();
        run_decode(EXP_RAND, -1, "rnd_full");
        check_all("rnd_full_hard");

        load_const(7);
        run_decode(EXP_CONST + 20, 50, "pause");

        rand_llrs(1'b1); load_frame();
        repeat (100) step();
        ext_reset = 1'b1;
        step();
        ext_reset = 1'b0;
        chk("ext_relay", 64'(relay), 64'(0));
        chk("ext_fid", 64'(f_id), 64'(exp_fid));
        step();
        chk("ext_idle", 64'(relay), 64'(0));
        rand_llrs(1'b1); load_frame();
        run_decode(EXP_RAND, -1, "after_ext");
        check_all("after_ext_hard");

        rand_llrs(1'b0); load_frame();
        begin
            int cnt;
            cnt = 0;
            while (relay[4:0] != 5'd10 && cnt < 1000) begin step(); cnt++; end
        end
        chk("mid_busy", 64'(relay), 64'(6'b101010));
        reset = 1'b1;
        #1;
        chk("mid_rst_dec", 64'(dec_out_fin), 64'(0));
        chk("mid_rst_relay", 64'(relay), 64'(0));
        chk("mid_rst_fid", 64'(f_id), 64'(0));
        step();
        reset = 1'b0; exp_fid = 1'b0;
        step();
        rand_llrs(1'b1); load_frame();
        run_decode(EXP_RAND, -1, "after_rst");
        check_all("after_rst_hard");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
